// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and elaboration helpers for serial_adder.
//   state_t    : FSM encoding (IDLE, RUN, DONE)
//   MIN_WIDTH  : smallest legal operand width
//   cnt_width  : digit-counter width for a given step count, never below 1
//   params_ok  : WIDTH/DIGIT legality check used at elaboration time
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned MIN_WIDTH = 2;

    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned digit);
        return (width >= MIN_WIDTH) && (digit >= 1) && (digit <= width) &&
               ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder, chained DIGIT times
// inside serial_adder.
//   a, b : operand bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder processing DIGIT bits per clock through a
// ripple chain of full_adder_cell instances, carry registered between digits.
// Takes WIDTH/DIGIT RUN cycles per operation.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready : result handshake (sum, cout, overflow)
// Optional macro SERIAL_ADDER_SUB_EN adds the sub port: b is inverted at
// capture and the carry seeded with 1, yielding a - b (cout=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = cnt_width(STEPS);

    if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   dsum;

    assign chain[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .c  (chain[i]),
            .s  (dsum[i]),
            .co (chain[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
`ifdef SERIAL_ADDER_SUB_EN
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New digit enters at the top so the LSB digit ends up lowest
                // after STEPS shifts.
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chain[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    // Output registers only update here, so sum stays stable
                    // outside DONE until the next result.
                    sum_d   = acc_d;
                    cout_d  = chain[DIGIT];
                    ovf_d   = chain[DIGIT-1] ^ chain[DIGIT];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-digit and a 16-bit/4-digit instance,
// directed vectors with hand-computed results, scoreboard queues popped by
// per-instance monitors on each output handshake.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit, DIGIT=1 instance
    logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub8;
`endif

    // 16-bit, DIGIT=4 instance
    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub16;
`endif

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (ovf8)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .sub       (sub8)
`endif
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
        .overflow  (ovf16)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .sub       (sub16)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // {sum[15:0], cout, overflow}
    logic [17:0] q8[$];
    logic [17:0] q16[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: compare on every accepted result
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && out_valid8 && out_ready8) begin
            chk("q8_nonempty", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e[17:2]));
                chk("cout8", 32'(cout8), 32'(e[1]));
                chk("ovf8", 32'(ovf8), 32'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && out_valid16 && out_ready16) begin
            chk("q16_nonempty", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("sum16", 32'(sum16), 32'(e[17:2]));
                chk("cout16", 32'(cout16), 32'(e[1]));
                chk("ovf16", 32'(ovf16), 32'(e[0]));
            end
        end
    end

    task automatic wait_ready8();
        int n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready8_wait", 32'(in_ready8), 32'd1);
    endtask

    task automatic wait_ready16();
        int n = 0;
        @(negedge clk);
        while (!in_ready16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready16_wait", 32'(in_ready16), 32'd1);
    endtask

    // Issue one 8-bit op, push its expected result, check accept-to-valid latency.
    task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic is, input logic [7:0] es, input logic ec,
                         input logic eo);
        int k;
        wait_ready8();
        a8 = ia;
        b8 = ib;
        cin8 = ic;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = is;
`else
        if (is) $display("note: sub vector skipped without subtract build");
`endif
        in_valid8 = 1'b1;
        q8.push_back({8'h00, es, ec, eo});
        @(posedge clk);
        #1 in_valid8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid8 && k < 40);
        chk("latency8", 32'(k), 32'd9);
    endtask

    initial begin : stim
        int k;
        logic seen;
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
        sub16 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'h00);
        chk("rst_cout8", 32'(cout8), 32'd0);
        chk("rst_ovf8", 32'(ovf8), 32'd0);
        chk("rst_in_ready16", 32'(in_ready16), 32'd1);
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        rst_n = 1'b1;

        // 8-bit directed vectors
        send8(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_sum8", 32'(sum8), 32'h51);
        chk("idle_out_valid8", 32'(out_valid8), 32'd0);
        send8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send8(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        send8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
`endif

        // 16-bit, DIGIT=4 with backpressure and ignored in_valid during RUN
        out_ready16 = 1'b0;
        wait_ready16();
        a16 = 16'h1234; b16 = 16'hEDCC; cin16 = 1'b0; in_valid16 = 1'b1;
        q16.push_back({16'h0000, 1'b1, 1'b0});
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 2) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
            end else begin
                in_valid16 = 1'b0;
            end
        end while (!out_valid16 && k < 40);
        in_valid16 = 1'b0;
        chk("latency16", 32'(k), 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid16", 32'(out_valid16), 32'd1);
            chk("bp_in_ready16", 32'(in_ready16), 32'd0);
            chk("bp_sum16", 32'(sum16), 32'h0000);
            chk("bp_cout16", 32'(cout16), 32'd1);
        end
        @(posedge clk);
        #1 out_ready16 = 1'b1;
        @(negedge clk);
        chk("hs_in_ready16", 32'(in_ready16), 32'd0);
        @(negedge clk);
        chk("post_hs_in_ready16", 32'(in_ready16), 32'd1);
        chk("post_hs_valid16", 32'(out_valid16), 32'd0);

        wait_ready16();
        a16 = 16'h8000; b16 = 16'hFFFF; cin16 = 1'b1; in_valid16 = 1'b1;
        q16.push_back({16'h8000, 1'b1, 1'b0});
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        cin16 = 1'b0;

        // Abort an 8-bit op with reset at step 3
        wait_ready16();
        wait_ready8();
        a8 = 8'h11; b8 = 8'h22; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | out_valid8;
        end
        rst_n = 1'b1;
        chk("abort_in_ready8", 32'(in_ready8), 32'd1);
        chk("abort_sum8", 32'(sum8), 32'h00);
        repeat (12) begin
            @(negedge clk);
            seen = seen | out_valid8;
        end
        chk("abort_no_valid8", 32'(seen), 32'd0);

        // Drain: every pushed expectation must have been matched
        k = 0;
        while ((q8.size() != 0 || q16.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
